// File: rtl/fp32_pkg.sv
// Shared definitions for the sequential fp32 arithmetic blocks (multiplier,
// divider): IEEE-754 single constants, field widths and the controller
// state type.
package fp32_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  localparam int FRAC_W = 23;              // stored fraction bits
  localparam int EXP_W  = 8;               // stored exponent bits
  localparam int MANT_W = FRAC_W + 1;      // fraction plus hidden bit
  localparam int PROD_W = 2 * MANT_W;      // full mantissa product
  localparam int EXPS_W = 10;              // signed working exponent

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_MUL,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } fp_state_e;

endpackage

// File: rtl/fp_mant_mul.sv
// Iterative radix-2 shift-add mantissa multiplier, 24x24 -> 48 bits.
//   clk, rst  : clock, synchronous active-low reset
//   load      : capture a/b and perform the iteration for multiplier bit 0
//   a, b      : mantissas with hidden bit attached
//   done      : one-cycle pulse; prod is final while done is high and
//               stays held until the next load
//   prod      : 48-bit product
// The load cycle consumes bit 0, the following 23 cycles consume bits 1..23,
// so the product is complete 24 edges after load was sampled.
module fp_mant_mul
  import fp32_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [MANT_W-1:0] a,
  input  logic [MANT_W-1:0] b,
  output logic              done,
  output logic [PROD_W-1:0] prod
);

  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] a_sh_q, a_sh_d;   // multiplicand aligned to current bit
  logic [MANT_W-1:0] b_sh_q, b_sh_d;   // remaining multiplier bits, LSB next
  logic [4:0]        cnt_q, cnt_d;
  logic              run_q, run_d;
  logic              done_q, done_d;

  always_comb begin
    acc_d  = acc_q;
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (load) begin
      acc_d  = b[0] ? {{MANT_W{1'b0}}, a} : '0;
      a_sh_d = {{(MANT_W-1){1'b0}}, a, 1'b0};
      b_sh_d = {1'b0, b[MANT_W-1:1]};
      cnt_d  = 5'd1;
      run_d  = 1'b1;
    end else if (run_q) begin
      if (b_sh_q[0]) acc_d = acc_q + a_sh_q;
      a_sh_d = a_sh_q << 1;
      b_sh_d = b_sh_q >> 1;
      cnt_d  = cnt_q + 5'd1;
      if (cnt_q == 5'd23) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q  <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign prod = acc_q;

endmodule

// File: rtl/fp32_multiplier.sv
// Sequential IEEE-754 single-precision multiplier.
//   clk, rst      : clock, synchronous active-low reset
//   start         : request, sampled only in IDLE
//   multiplicand  : operand A, captured on the accepting edge
//   multiplier    : operand B, captured on the accepting edge
//   valid         : one-cycle pulse in the DONE cycle
//   busy          : high from accept through DONE inclusive
//   out_reg       : result, held until the next result
// Handshake: start is taken on an edge where the block is IDLE (busy=0);
// valid pulses exactly once per accepted request, in the DONE cycle, and
// out_reg is written only on the edge entering DONE. start while busy is
// dropped. Inputs that are zero or subnormal are flushed to signed zero.
// Build option: define FP_MUL_RNE_EN for round-to-nearest-even; otherwise
// the result is truncated (same latency either way).
module fp32_multiplier
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        valid,
  output logic        busy,
  output logic [31:0] out_reg
);

  fp_state_e                 state_q, state_d;
  logic [31:0]               a_q, a_d, b_q, b_d;
  logic                      sign_q, sign_d;
  logic signed [EXPS_W-1:0]  exp_q, exp_d;
  logic [FRAC_W-1:0]         mant_q, mant_d;
  logic [31:0]               out_q, out_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
`ifdef FP_MUL_RNE_EN
  logic                      guard_q, guard_d;
  logic                      sticky_q, sticky_d;
`endif

  logic                      load, done;
  logic [PROD_W-1:0]         prod;

  fp_mant_mul u_mant_mul (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .a    ({1'b1, a_q[FRAC_W-1:0]}),
    .b    ({1'b1, b_q[FRAC_W-1:0]}),
    .done (done),
    .prod (prod)
  );

  logic [EXP_W-1:0]         ea, eb;
  logic                     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic                     round_up;
  logic [FRAC_W:0]          mant_sum;
  logic signed [EXPS_W-1:0] exp_r;

  assign ea     = a_q[30:23];
  assign eb     = b_q[30:23];
  assign a_nan  = (ea == 8'hFF) && (a_q[FRAC_W-1:0] != '0);
  assign b_nan  = (eb == 8'hFF) && (b_q[FRAC_W-1:0] != '0);
  assign a_inf  = (ea == 8'hFF) && (a_q[FRAC_W-1:0] == '0);
  assign b_inf  = (eb == 8'hFF) && (b_q[FRAC_W-1:0] == '0);
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);

`ifdef FP_MUL_RNE_EN
  assign round_up = guard_q & (sticky_q | mant_q[0]);
`else
  assign round_up = 1'b0;
  // Below-lsb product bits only matter when rounding to nearest.
  logic [22:0] unused_prod_lo;
  assign unused_prod_lo = prod[22:0];
`endif

  // A carry out of the fraction means 1.111..1 rounded up to 10.000..0:
  // the fraction wraps to zero and the exponent absorbs the carry.
  assign mant_sum = {1'b0, mant_q} + {{FRAC_W{1'b0}}, round_up};
  assign exp_r    = exp_q + {{(EXPS_W-1){1'b0}}, mant_sum[FRAC_W]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    out_d   = out_q;
    load    = 1'b0;
`ifdef FP_MUL_RNE_EN
    guard_d  = guard_q;
    sticky_d = sticky_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = multiplicand;
          b_d     = multiplier;
          state_d = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        sign_d = a_q[31] ^ b_q[31];
        exp_d  = EXPS_W'({2'b00, ea} + {2'b00, eb} - 10'd127);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
          out_d   = QNAN;
          state_d = ST_DONE;
        end else if (a_inf || b_inf) begin
          out_d   = {a_q[31] ^ b_q[31], POS_INF[30:0]};
          state_d = ST_DONE;
        end else if (a_zero || b_zero) begin
          out_d   = {a_q[31] ^ b_q[31], 31'b0};
          state_d = ST_DONE;
        end else begin
          load    = 1'b1;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        if (done) state_d = ST_NORM;
      end
      ST_NORM: begin
        // Product of two [1,2) mantissas lies in [1,4); bit 47 marks [2,4).
        if (prod[47]) begin
          mant_d = prod[46:24];
          exp_d  = exp_q + 10'sd1;
`ifdef FP_MUL_RNE_EN
          guard_d  = prod[23];
          sticky_d = |prod[22:0];
`endif
        end else begin
          mant_d = prod[45:23];
`ifdef FP_MUL_RNE_EN
          guard_d  = prod[22];
          sticky_d = |prod[21:0];
`endif
        end
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        if (exp_r >= 10'sd255)
          out_d = {sign_q, POS_INF[30:0]};
        else if (exp_r <= 10'sd0)
          out_d = {sign_q, 31'b0};
        else
          out_d = {sign_q, exp_r[EXP_W-1:0], mant_sum[FRAC_W-1:0]};
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_DONE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FP_MUL_RNE_EN
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef FP_MUL_RNE_EN
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
`endif
    end
  end

  assign valid   = valid_q;
  assign busy    = busy_q;
  assign out_reg = out_q;

endmodule

// File: tb/tb_fp32_multiplier.sv
// Self-checking bench for fp32_multiplier: directed steps from the test plan
// followed by randomized operands checked against a numeric reference model.
module tb_fp32_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        valid;
  logic        busy;
  logic [31:0] out_reg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp32_multiplier dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .valid        (valid),
    .busy         (busy),
    .out_reg      (out_reg)
  );

  // ---------------- reference model ----------------
  // Exact integer product, scaled to 24 significant bits, then rounded by
  // comparing the discarded remainder against one half.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          output bit special);
    bit               s;
    int               ea, eb, e, sh;
    longint unsigned  p, m, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    special = 1'b1;
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
    if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return 32'h7FC00000;
    if (ea == 255 || eb == 255) return {s, 31'h7F800000};
    if (ea == 0 || eb == 0) return {s, 31'h0};
    special = 1'b0;
    p  = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    e  = ea + eb - 127 + (sh - 23);
    m  = p >> sh;
    rem  = p - (m << sh);
    half = 64'd1 << (sh - 1);
`ifdef FP_MUL_RNE_EN
    if (rem > half || (rem == half && m[0])) m = m + 1;
`endif
    if (m == (64'd1 << 24)) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 31'h7F800000};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] f;
    int          r;
    r = $urandom_range(0, 9);
    f = 23'($urandom);
    if (r == 0) e = 8'h00;
    else if (r == 1) begin
      e = 8'hFF;
      if ($urandom_range(0, 1) == 0) f = '0;
    end else e = 8'($urandom_range(1, 254));
    return {1'($urandom_range(0, 1)), e, f};
  endfunction

  // ---------------- check helpers ----------------
  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Raise start for one cycle; returns at the first negedge after the
  // accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  // Wait (bounded) for valid. n counts edges since acceptance, counting the
  // accepting edge as 1. Returns at the negedge inside the DONE cycle.
  task automatic collect(input string tag, input logic [31:0] exp_res,
                         input int exp_lat, input int n_init);
    int n;
    bit busy_ok;
    n = n_init;
    busy_ok = 1'b1;
    while (valid !== 1'b1 && n < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check_int({tag, "_latency"}, n, exp_lat);
    check_int({tag, "_busy_hold"}, int'(busy_ok), 1);
    check_int({tag, "_busy_done"}, int'(busy), 1);
    check32({tag, "_result"}, out_reg, exp_res);
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat);
    issue(a, b);
    collect(tag, exp_res, exp_lat, 1);
  endtask

  task automatic count_valid(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (valid === 1'b1) pulses++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ra, rb, rexp;
    bit          rspecial;
    int          pulses;

    rst = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (3) @(negedge clk);
    check_int("reset_valid", int'(valid), 0);
    check_int("reset_busy", int'(busy), 0);
    check32("reset_out", out_reg, 32'h0);
    rst = 1'b1;

    do_op("mul_2x3", 32'h40000000, 32'h40400000, 32'h40C00000, 28);
`ifdef FP_MUL_RNE_EN
    do_op("round_sq", 32'h3FC00001, 32'h3FC00001, 32'h40100002, 28);
`else
    do_op("round_sq", 32'h3FC00001, 32'h3FC00001, 32'h40100001, 28);
`endif
    do_op("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 2);
    do_op("ninf_x_2", 32'hFF800000, 32'h40000000, 32'hFF800000, 2);
    do_op("nzero_x_1", 32'h80000000, 32'h3F800000, 32'h80000000, 2);
    do_op("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000, 28);
    do_op("underflow", 32'h00800000, 32'h00800000, 32'h00000000, 28);
    do_op("nan_in", 32'h7FC12345, 32'h3F800000, 32'h7FC00000, 2);

    // start re-pulsed during MUL with other operands must be ignored
    issue(32'h40000000, 32'h40400000);
    @(negedge clk);
    multiplicand = 32'h41200000;
    multiplier   = 32'h41300000;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    collect("repulse", 32'h40C00000, 28, 3);
    count_valid(35, pulses);
    check_int("repulse_single_valid", pulses, 0);

    // back-to-back: second start lands in the IDLE cycle after DONE
    do_op("b2b_first", 32'h3FC00000, 32'h40000000, 32'h40400000, 28);
    do_op("b2b_second", 32'hC0000000, 32'h40400000, 32'hC0C00000, 28);

    // reset during MUL discards the operation
    issue(32'h40000000, 32'h40400000);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_int("midreset_busy", int'(busy), 0);
    check_int("midreset_valid", int'(valid), 0);
    check32("midreset_out", out_reg, 32'h0);
    rst = 1'b1;
    count_valid(40, pulses);
    check_int("midreset_no_valid", pulses, 0);
    do_op("after_reset", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 28);

    // randomized operands against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = rand_fp();
      rb = rand_fp();
      rexp = ref_mul(ra, rb, rspecial);
      do_op($sformatf("rand%0d_%08h_%08h", i, ra, rb), ra, rb, rexp, rspecial ? 2 : 28);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp32_multiplier.md
# fp32_multiplier

Sequential IEEE-754 single-precision multiplier with the same start/busy/valid handshake and result register as the divider. It is the companion datapath in the floating-point arithmetic set: the divider inverts a product, this block forms one. Both sit behind the same controller. Mantissa product is computed by an iterative radix-2 shift-add engine, then normalised and rounded.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low; sampled on rising edge of clk.
- start  in  1  request; sampled only in IDLE.
- multiplicand  in  32  operand A, IEEE-754 single; captured on accepting edge.
- multiplier  in  32  operand B, IEEE-754 single; captured on accepting edge.
- valid  out  1  one-cycle pulse; out_reg holds the new result.
- busy  out  1  high from accept until the DONE cycle, inclusive.
- out_reg  out  32  result; held until the next result is written.

## Operation
- FSM: IDLE, UNPACK, MUL, NORM, ROUND, DONE.
- IDLE -> UNPACK: edge with start=1; operands latched; busy rises.
- UNPACK:
  - Sign = sA^sB.
  - Exponent sum eA+eB-127 in 10-bit signed.
  - Hidden bits attached.
  - Specials resolved, jumping straight to DONE with out_reg loaded:
    - any NaN -> 32'h7FC00000
    - inf*0 -> 32'h7FC00000
    - inf*finite -> signed inf
    - zero or subnormal input -> signed zero (inputs flush to zero)
- MUL: 24 iterations, one multiplier bit per cycle, into a 48-bit accumulator. Then NORM.
- NORM:
  - If product bit47 is set: shift right 1, exponent+1.
  - Form mantissa[22:0], guard, and sticky (OR of remaining bits).
- ROUND: round per Configuration; a mantissa carry-out increments the exponent.
- Range checks:
  - Exponent >=255 -> signed inf (7F800000 / FF800000).
  - Exponent <=0 -> signed zero.
- DONE: valid=1 and busy=1 for exactly this cycle; next edge -> IDLE.
- start outside IDLE is ignored; no queuing.
- Reset (rst=0 at an edge, any state): state=IDLE, valid=0, busy=0, out_reg=0, internal registers cleared. An in-flight operation is discarded with no valid pulse.

## Timing
- Accepting edge = E0.
- Normal path: UNPACK after E0, MUL after E1, 24 MUL edges E1..E24, NORM after E25, ROUND after E26, DONE after E27. Result latency: valid high in the cycle after E27.
- Special path: DONE after E1, so valid high in the cycle after E1.
- IDLE after E28 on the normal path, after E2 on the special path. start may be high in that same IDLE cycle; back-to-back throughput is 29 cycles.
- out_reg changes only on the edge that enters DONE, or on reset.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- FP_MUL_RNE_EN defined: round-to-nearest-even on guard/sticky.
  - Round up if guard and (sticky or lsb).
  - Rounding may carry into the exponent and produce overflow to inf.
- FP_MUL_RNE_EN undefined: truncate (round toward zero). The guard/sticky logic is removed; ROUND still takes one cycle, so latency is identical.

## Structure
- Shared package fp32_pkg holds:
  - EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, POS_INF=32'h7F800000
  - field-extract widths
  - state enum type
- The divider imports the same package.
- Sub-module fp_mant_mul: 24x24 iterative shift-add engine.
  - Ports: clk, rst, load, a[23:0], b[23:0], done, prod[47:0].
  - Takes 24 cycles from load; done pulses when prod is final.
  - Top-level FSM owns unpack, normalise, round and specials.

## Test plan
- 0x40000000 * 0x40400000 (2.0*3.0) -> out_reg=0x40C00000; valid exactly 28 edges after accept; busy high throughout.
- 0x3FC00001 * 0x3FC00001 -> out_reg=0x40100002 with FP_MUL_RNE_EN, 0x40100001 without.
- Specials:
  - 0x7F800000 * 0x00000000 -> 0x7FC00000, valid 2 edges after accept.
  - 0xFF800000 * 0x40000000 -> 0xFF800000.
  - 0x80000000 * 0x3F800000 -> 0x80000000.
- Range: 0x7F000000 * 0x7F000000 -> 0x7F800000 (overflow); 0x00800000 * 0x00800000 -> 0x00000000 (underflow flush).
- start re-pulsed mid-MUL with different operands is ignored: first result 0x40C00000 returned, single valid pulse. Back-to-back start in the IDLE cycle after DONE is accepted.
- Reset mid-op: rst=0 at cycle 10 of MUL -> next cycle busy=0, valid=0, out_reg=0, and no valid pulse follows. A fresh 1.5*1.5 then yields 0x40100000.
